// File: rtl/fsub.sv
// fsub: two-stage pipelined binary32 subtractor, y = x1 - x2.
// Stage 1 swaps the operands so the larger magnitude comes first and aligns
// the smaller one. Stage 2 adds or subtracts, normalises, rounds and packs.
// One advance signal stalls both stages together when the output is full and
// the consumer is not taking it.
module fsub (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);

  // Pipeline control
  logic        adv;
  logic        accept;

  // Stage-1 combinational values
  logic        eff_sign2;
  logic        op_sub;
  logic        x1_larger;
  logic        big_sign;
  logic [7:0]  big_exp;
  logic [22:0] big_man;
  logic [7:0]  small_exp;
  logic [22:0] small_man;
  logic [7:0]  ediff;
  logic [26:0] small_aligned;
  logic        small_live;

  // Stage-1 registers
  logic        s1_valid_q, s1_valid_d;
  logic        s1_ss_q,    s1_ss_d;
  logic        s1_sub_q,   s1_sub_d;
  logic [7:0]  s1_es_q,    s1_es_d;
  logic [22:0] s1_ms_q,    s1_ms_d;
  logic [26:0] s1_mia_q,   s1_mia_d;
  logic        s1_live_q,  s1_live_d;

  // Stage-2 combinational values
  logic [26:0]       big_ext;
  logic [26:0]       calc;
  logic [4:0]        lz;
  logic              lz_found;
  logic [26:0]       my;
  logic              round_carry;
  logic signed [9:0] ey;
  logic [22:0]       mant_sum;
  logic [31:0]       result;
  logic              unused_norm_bits;

  // Output registers
  logic        out_valid_q, out_valid_d;
  logic [31:0] y_q,         y_d;

  // Whole pipeline moves only when the output slot is empty or being drained
  always_comb begin
    adv    = !out_valid_q || out_ready;
    accept = in_valid && adv;
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign y         = y_q;

  // Stage 1: pick the larger magnitude, align the smaller one under it
  always_comb begin
    eff_sign2 = ~x2[31];
    op_sub    = x1[31] ^ eff_sign2;
    x1_larger = x1[30:0] > x2[30:0];
    if (x1_larger) begin
      big_sign  = x1[31];
      big_exp   = x1[30:23];
      big_man   = x1[22:0];
      small_exp = x2[30:23];
      small_man = x2[22:0];
    end else begin
      big_sign  = eff_sign2;
      big_exp   = x2[30:23];
      big_man   = x2[22:0];
      small_exp = x1[30:23];
      small_man = x1[22:0];
    end
    ediff         = big_exp - small_exp;
    small_aligned = {2'b01, small_man, 2'b00} >> ediff[4:0];
    // A denormal or far-too-small operand cannot change the result
    small_live    = (small_exp != 8'd0) && (ediff < 8'd32);
  end

  // Stage-1 next state: capture on accept, otherwise hold; valid follows adv
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_ss_d    = s1_ss_q;
    s1_sub_d   = s1_sub_q;
    s1_es_d    = s1_es_q;
    s1_ms_d    = s1_ms_q;
    s1_mia_d   = s1_mia_q;
    s1_live_d  = s1_live_q;
    if (adv) begin
      s1_valid_d = accept;
    end
    if (accept) begin
      s1_ss_d   = big_sign;
      s1_sub_d  = op_sub;
      s1_es_d   = big_exp;
      s1_ms_d   = big_man;
      s1_mia_d  = small_aligned;
      s1_live_d = small_live;
    end
  end

  // Stage 2: add/subtract, count leading zeros and shift the top bit to bit 26
  always_comb begin
    big_ext  = {2'b01, s1_ms_q, 2'b00};
    calc     = s1_sub_q ? (big_ext - s1_mia_q) : (big_ext + s1_mia_q);
    lz       = 5'd0;
    lz_found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!lz_found) begin
        if (calc[i]) begin
          lz_found = 1'b1;
        end else begin
          lz = lz + 5'd1;
        end
      end
    end
    my = calc << lz;
  end

  // Stage 2: round on the first guard bit and pick the packed result
  always_comb begin
    round_carry      = &my[25:2];
    // Ten bits so that the largest exponents cannot wrap negative
    ey               = $signed({2'b00, s1_es_q}) - $signed({5'b00000, lz})
                       + 10'sd1 + $signed({9'b0, round_carry});
    mant_sum         = my[25:3] + {22'b0, my[2]};
    unused_norm_bits = ^{my[26], my[1:0]};
    if (!s1_live_q) begin
      result = {s1_ss_q, s1_es_q, s1_ms_q};
    end else if (calc == 27'd0) begin
      result = 32'h0000_0000;
    end else if (ey <= 10'sd0) begin
      result = {s1_ss_q, 31'b0};
    end else if (ey >= 10'sd255) begin
      result = {s1_ss_q, 8'hFF, 23'b0};
    end else begin
      result = {s1_ss_q, ey[7:0], mant_sum};
    end
  end

  // Output slot: refill from stage 1 on advance, hold y across bubbles/stalls
  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    if (adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        y_d = result;
      end
    end
  end

  // State registers with synchronous reset discarding everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_ss_q     <= 1'b0;
      s1_sub_q    <= 1'b0;
      s1_es_q     <= 8'd0;
      s1_ms_q     <= 23'd0;
      s1_mia_q    <= 27'd0;
      s1_live_q   <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= 32'd0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_ss_q     <= s1_ss_d;
      s1_sub_q    <= s1_sub_d;
      s1_es_q     <= s1_es_d;
      s1_ms_q     <= s1_ms_d;
      s1_mia_q    <= s1_mia_d;
      s1_live_q   <= s1_live_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
    end
  end

endmodule

// File: tb/tb_fsub.sv
// tb_fsub: directed and randomized checks of fsub against an arithmetic
// reference and a two-slot pipeline occupancy model.
module tb_fsub;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;

  int n_checks;
  int n_fail;

  // Model: slot 0 is the operand pair in flight, slot 1 is the output
  logic        m_v [2];
  logic [31:0] m_y [2];

  fsub dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Reference difference from integer arithmetic on scaled significands
  function automatic logic [31:0] ref_fsub(input logic [31:0] a, input logic [31:0] b);
    bit     s_a, s_b, s_big;
    int     e_big, e_small, d, p, e;
    longint f_big, f_small, big_v, small_v, r, n, m24;
    s_a = a[31];
    s_b = ~b[31];
    if (a[30:0] > b[30:0]) begin
      s_big = s_a; e_big = int'(a[30:23]); f_big = longint'(a[22:0]);
      e_small = int'(b[30:23]); f_small = longint'(b[22:0]);
    end else begin
      s_big = s_b; e_big = int'(b[30:23]); f_big = longint'(b[22:0]);
      e_small = int'(a[30:23]); f_small = longint'(a[22:0]);
    end
    d = e_big - e_small;
    if (e_small == 0 || d >= 32) return {s_big, e_big[7:0], f_big[22:0]};
    big_v   = (64'sd8388608 + f_big) * 4;
    small_v = ((64'sd8388608 + f_small) * 4) >> d;
    r = (s_a != s_b) ? big_v - small_v : big_v + small_v;
    if (r == 0) return 32'h0000_0000;
    p = 0;
    for (int k = 0; k < 40; k++) if (r[k]) p = k;
    e   = e_big + p - 25;
    n   = r << (26 - p);
    m24 = (n >> 3) + ((n >> 2) & 1);
    if (m24 >= (64'sd1 << 24)) begin
      m24 = m24 >> 1;
      e   = e + 1;
    end
    if (e <= 0) return {s_big, 31'b0};
    if (e >= 255) return {s_big, 8'hFF, 23'b0};
    return {s_big, e[7:0], m24[22:0]};
  endfunction

  // Second operand, often close to the first so cancellation paths get exercised
  function automatic logic [31:0] rand_partner(input logic [31:0] a);
    logic [31:0] r;
    int          e;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: ;
      1: begin
        e = int'(a[30:23]) + int'($urandom_range(0, 8)) - 4;
        if (e < 0) e = 0;
        if (e > 255) e = 255;
        r[30:23] = e[7:0];
      end
      2: r = a;
      3: r = {r[31], a[30:23], a[22:0] ^ (23'd1 << $urandom_range(0, 22))};
      default: begin
        e = int'(a[30:23]) + int'($urandom_range(0, 60)) - 30;
        if (e < 0) e = 0;
        if (e > 255) e = 255;
        r[30:23] = e[7:0];
      end
    endcase
    return r;
  endfunction

  // Single comparison point
  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle from a negedge, check in_ready, step the model at posedge
  task automatic applyStimulus(input logic iv, input logic [31:0] a, input logic [31:0] b,
                               input logic ordy);
    logic adv_m;
    logic acc;
    in_valid  = iv;
    x1        = a;
    x2        = b;
    out_ready = ordy;
    #1;
    adv_m = !m_v[1] || ordy;
    compare("in_ready", {31'b0, in_ready}, {31'b0, adv_m});
    acc = iv && adv_m;
    @(posedge clk);
    if (rst) begin
      m_v[0] = 1'b0;
      m_v[1] = 1'b0;
    end else if (adv_m) begin
      m_v[1] = m_v[0];
      if (m_v[0]) m_y[1] = m_y[0];
      m_v[0] = acc;
      if (acc) m_y[0] = ref_fsub(a, b);
    end
    @(negedge clk);
  endtask

  // Compare the output slot against the model
  task automatic checkOutput(input string tag);
    compare({tag, "/out_valid"}, {31'b0, out_valid}, {31'b0, m_v[1]});
    if (m_v[1]) compare({tag, "/y"}, y, m_y[1]);
  endtask

  // One pair through an otherwise idle pipe, with a fixed expected result
  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
    applyStimulus(1'b1, a, b, 1'b1);
    checkOutput(tag);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    checkOutput(tag);
    compare({tag, "/const_valid"}, {31'b0, out_valid}, 32'd1);
    compare({tag, "/const_y"}, y, exp);
  endtask

  // Directed steps followed by randomized traffic
  initial begin
    logic [31:0] ra;
    clk = 1'b0; rst = 1'b1; in_valid = 1'b0; x1 = '0; x2 = '0; out_ready = 1'b1;
    n_checks = 0; n_fail = 0;
    m_v[0] = 1'b0; m_v[1] = 1'b0; m_y[0] = '0; m_y[1] = '0;

    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    rst = 1'b0;
    compare("reset/out_valid", {31'b0, out_valid}, 32'd0);
    compare("reset/y", y, 32'd0);
    compare("reset/in_ready", {31'b0, in_ready}, 32'd1);

    directed("3-1",      32'h4040_0000, 32'h3F80_0000, 32'h4000_0000);
    directed("1-3",      32'h3F80_0000, 32'h4040_0000, 32'hC000_0000);
    directed("1-1",      32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000);
    directed("1-ulp",    32'h3F80_0000, 32'h3380_0000, 32'h3F7F_FFFF);
    directed("ediff32",  32'h4F80_0000, 32'h3F80_0000, 32'h4F80_0000);
    directed("underflow",32'h0080_0000, 32'h00FF_FFFF, 32'h8000_0000);
    directed("overflow", 32'h7F7F_FFFF, 32'hF380_0000, 32'h7F80_0000);

    // Back-to-back with a three-cycle output stall
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    applyStimulus(1'b1, 32'h4040_0000, 32'h3F80_0000, 1'b1);
    applyStimulus(1'b1, 32'h3F80_0000, 32'h4040_0000, 1'b1);
    checkOutput("b2b");
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1'b1, 32'h40A0_0000, 32'h3F80_0000, 1'b0);
      checkOutput("stall");
      compare("stall/y_hold", y, 32'h4000_0000);
      compare("stall/in_ready", {31'b0, in_ready}, 32'd0);
    end
    applyStimulus(1'b1, 32'h40A0_0000, 32'h3F80_0000, 1'b1);
    checkOutput("release1");
    compare("release1/y", y, 32'hC000_0000);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    checkOutput("release2");
    compare("release2/y", y, 32'h4080_0000);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    compare("release3/out_valid", {31'b0, out_valid}, 32'd0);

    // Reset with two pairs in flight
    applyStimulus(1'b1, 32'h4040_0000, 32'h3F80_0000, 1'b1);
    applyStimulus(1'b1, 32'h40A0_0000, 32'h3F80_0000, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    rst = 1'b0;
    compare("midrst/out_valid", {31'b0, out_valid}, 32'd0);
    compare("midrst/y", y, 32'd0);
    compare("midrst/in_ready", {31'b0, in_ready}, 32'd1);
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
      compare("midrst/no_ghost", {31'b0, out_valid}, 32'd0);
    end

    // Randomized traffic with random back-pressure and rare resets
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      ra  = $urandom;
      applyStimulus($urandom_range(0, 3) != 0, ra, rand_partner(ra), $urandom_range(0, 9) < 7);
      rst = 1'b0;
      checkOutput("rand");
    end
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
      checkOutput("drain");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
